sha256_round_ctrl: RTL and testbench



---
 rtl/sha256_pkg.sv | 51 +++++
 rtl/func_t1.sv | 21 ++
 rtl/func_t2.sv | 18 +
 rtl/sha256_msg_sched.sv | 35 +++
 rtl/sha256_round_ctrl.sv | 145 ++++++++++++++
 tb/tb_sha256_round_ctrl.sv | 207 ++++++++++++++++++++
 6 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM state type and rotate helper for the round controller.
// SHA224_EN additionally provides the SHA-224 initial hash values.
package sha256_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam word_t K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam word_t IV_256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

`ifdef SHA224_EN
  localparam word_t IV_224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };
`endif

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

endpackage

// File: rtl/func_t1.sv
// SHA-256 T1 term: h + Sigma1(e) + Ch(e,f,g) + K[t] + W[t], purely combinational.
module func_t1
  import sha256_pkg::*;
(
  input  logic [31:0] i_e,
  input  logic [31:0] i_f,
  input  logic [31:0] i_g,
  input  logic [31:0] i_h,
  input  logic [31:0] i_k,
  input  logic [31:0] i_w,
  output logic [31:0] o_t1
);

  logic [31:0] w_sigma1;
  logic [31:0] w_ch;

  assign w_sigma1 = rotr(i_e, 6) ^ rotr(i_e, 11) ^ rotr(i_e, 25);
  assign w_ch     = (i_e & i_f) ^ (~i_e & i_g);
  assign o_t1     = i_h + w_sigma1 + w_ch + i_k + i_w;

endmodule

// File: rtl/func_t2.sv
// SHA-256 T2 term: Sigma0(a) + Maj(a,b,c), purely combinational.
module func_t2
  import sha256_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_c,
  output logic [31:0] o_t2
);

  logic [31:0] w_sigma0;
  logic [31:0] w_maj;

  assign w_sigma0 = rotr(i_a, 2) ^ rotr(i_a, 13) ^ rotr(i_a, 22);
  assign w_maj    = (i_a & i_b) ^ (i_a & i_c) ^ (i_b & i_c);
  assign o_t2     = w_sigma0 + w_maj;

endmodule

// File: rtl/sha256_msg_sched.sv
// Message schedule as a 16-word sliding window; o_w is W[t] for the current round.
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [511:0] i_block,
  output logic [31:0]  o_w
);

  logic [31:0] r_win [16];
  logic [31:0] w_s0;
  logic [31:0] w_s1;
  logic [31:0] w_next;

  // Window holds W[t..t+15]; the tail word computed here is W[t+16].
  assign w_s0   = rotr(r_win[1], 7) ^ rotr(r_win[1], 18) ^ (r_win[1] >> 3);
  assign w_s1   = rotr(r_win[14], 17) ^ rotr(r_win[14], 19) ^ (r_win[14] >> 10);
  assign w_next = w_s1 + r_win[9] + w_s0 + r_win[0];
  assign o_w    = r_win[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) r_win[i] <= '0;
    end else if (i_load) begin
      for (int i = 0; i < 16; i++) r_win[i] <= i_block[511 - 32*i -: 32];
    end else if (i_shift) begin
      for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
      r_win[15] <= w_next;
    end
  end

endmodule

// File: rtl/sha256_round_ctrl.sv
// Iterative SHA-256 compression controller, one round per clock.
// Define SHA224_EN to add in_sha224 and the SHA-224 initial hash values.
module sha256_round_ctrl
  import sha256_pkg::*;
#(
  parameter int NUM_ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_start,
  input  logic         in_init,
  input  logic [511:0] in_block,
`ifdef SHA224_EN
  input  logic         in_sha224,
`endif
  output logic         out_busy,
  output logic         out_done,
  output logic [255:0] out_digest,
  output logic [1:0]   out_dbg_state
);

  // Handshake: in_start is taken only while IDLE (out_busy low, out_done low) on a
  // rising edge; out_busy then stays high until DONE, and out_done is a one-cycle
  // valid strobe for out_digest. There is no backpressure; starts while busy are dropped.

  localparam logic [5:0] LAST_T = 6'(NUM_ROUNDS - 1);

  state_t      r_state;
  logic        r_busy;
  logic        r_done;
  logic [5:0]  r_t;
  logic [31:0] r_hash   [8];
  logic [31:0] r_digest [8];
  logic [31:0] r_work   [8];

  logic [31:0] w_iv   [8];
  logic [31:0] w_seed [8];
  logic [31:0] w_k;
  logic [31:0] w_w;
  logic [31:0] w_t1;
  logic [31:0] w_t2;
  logic        w_accept;

  assign w_accept = (r_state == IDLE) && in_start;
  assign w_k      = K_TABLE[r_t];

  always_comb begin
    for (int i = 0; i < 8; i++) w_iv[i] = IV_256[i];
`ifdef SHA224_EN
    if (in_sha224) begin
      for (int i = 0; i < 8; i++) w_iv[i] = IV_224[i];
    end
`endif
    for (int i = 0; i < 8; i++) w_seed[i] = in_init ? w_iv[i] : r_hash[i];
  end

  sha256_msg_sched u_sched (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_accept),
    .i_shift (r_state == ROUND),
    .i_block (in_block),
    .o_w     (w_w)
  );

  func_t1 u_t1 (
    .i_e  (r_work[4]),
    .i_f  (r_work[5]),
    .i_g  (r_work[6]),
    .i_h  (r_work[7]),
    .i_k  (w_k),
    .i_w  (w_w),
    .o_t1 (w_t1)
  );

  func_t2 u_t2 (
    .i_a  (r_work[0]),
    .i_b  (r_work[1]),
    .i_c  (r_work[2]),
    .o_t2 (w_t2)
  );

  // r_work[0..7] are a..h; r_digest only moves at FINAL so the consumer never sees a reload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_t     <= '0;
      for (int i = 0; i < 8; i++) begin
        r_hash[i]   <= IV_256[i];
        r_digest[i] <= IV_256[i];
        r_work[i]   <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (in_start) begin
            for (int i = 0; i < 8; i++) r_work[i] <= w_seed[i];
            if (in_init) begin
              for (int i = 0; i < 8; i++) r_hash[i] <= w_iv[i];
            end
            r_t     <= '0;
            r_busy  <= 1'b1;
            r_state <= ROUND;
          end
        end
        ROUND: begin
          r_work[0] <= w_t1 + w_t2;
          r_work[1] <= r_work[0];
          r_work[2] <= r_work[1];
          r_work[3] <= r_work[2];
          r_work[4] <= r_work[3] + w_t1;
          r_work[5] <= r_work[4];
          r_work[6] <= r_work[5];
          r_work[7] <= r_work[6];
          r_t       <= r_t + 6'd1;
          if (r_t == LAST_T) r_state <= FINAL;
        end
        FINAL: begin
          for (int i = 0; i < 8; i++) begin
            r_hash[i]   <= r_hash[i] + r_work[i];
            r_digest[i] <= r_hash[i] + r_work[i];
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_busy      = r_busy;
  assign out_done      = r_done;
  assign out_dbg_state = r_state;
  assign out_digest    = {r_digest[0], r_digest[1], r_digest[2], r_digest[3],
                          r_digest[4], r_digest[5], r_digest[6], r_digest[7]};

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed bench for sha256_round_ctrl: scoreboard of expected digests and done cycles.
module tb_sha256_round_ctrl;

  logic         clk;
  logic         rst;
  logic         in_start;
  logic         in_init;
  logic [511:0] in_block;
`ifdef SHA224_EN
  logic         in_sha224;
`endif
  logic         out_busy;
  logic         out_done;
  logic [255:0] out_digest;
  logic [1:0]   out_dbg_state;

  sha256_round_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .in_start      (in_start),
    .in_init       (in_init),
    .in_block      (in_block),
`ifdef SHA224_EN
    .in_sha224     (in_sha224),
`endif
    .out_busy      (out_busy),
    .out_done      (out_done),
    .out_digest    (out_digest),
    .out_dbg_state (out_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [255:0] IV_DIG   = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] ABC_DIG  = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] NULL_DIG = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] TWO_DIG  = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [255:0] FULL     = {256{1'b1}};

  logic [511:0] blk_abc;
  logic [511:0] blk_null;
  logic [511:0] blk_two1;
  logic [511:0] blk_two2;

  // scoreboard
  logic [255:0] exp_q[$];
  logic [255:0] mask_q[$];
  int           due_q[$];
  int           chk_cnt = 0;
  int           pass_cnt = 0;
  logic [255:0] last_digest = IV_DIG;
  bit           last_known = 1'b1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // driver tasks
  task automatic start_block(input logic [511:0] blk, input logic init, input logic s224,
                             input logic [255:0] exp, input logic [255:0] msk);
    @(negedge clk);
    in_block = blk;
    in_init  = init;
`ifdef SHA224_EN
    in_sha224 = s224;
`else
    if (s224) $display("note: sha224 request ignored in this build");
`endif
    in_start = 1'b1;
    @(posedge clk);
    #1;
    in_start = 1'b0;
    in_init  = ~init;
    in_block = {16{32'hdeadbeef}};
    chk("busy_accept", {255'd0, out_busy}, 256'd1);
    if (last_known) chk("digest_hold", out_digest, last_digest);
    exp_q.push_back(exp);
    mask_q.push_back(msk);
    due_q.push_back(cyc + 65);
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 90 && !seen; i++) begin
      @(negedge clk);
      if (out_done) seen = 1'b1;
    end
    if (!seen) begin
      chk_cnt++;
      $display("FAIL %s: out_done not seen within 90 cycles, required one pulse", name);
      exp_q.delete();
      mask_q.delete();
      due_q.delete();
    end
  endtask

  // monitor
  initial begin
    logic [255:0] e;
    logic [255:0] m;
    int           d;
    forever begin
      @(negedge clk);
      if (!rst && out_done) begin
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_done: out_done=1 at cycle %0d, required none", cyc);
        end else begin
          e = exp_q.pop_front();
          m = mask_q.pop_front();
          d = due_q.pop_front();
          if (m != '0) chk("digest", out_digest & m, e);
          chk("done_latency", 256'(cyc), 256'(d));
          chk("busy_at_done", {255'd0, out_busy}, 256'd0);
          last_known  = (m == FULL);
          last_digest = e;
        end
      end
    end
  end

  // stimulus
  initial begin
    blk_abc  = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
    blk_null = {32'h80000000, {15{32'h00000000}}};
    blk_two1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    blk_two2 = {{15{32'h00000000}}, 32'h000001c0};

    rst      = 1'b1;
    in_start = 1'b0;
    in_init  = 1'b0;
    in_block = '0;
`ifdef SHA224_EN
    in_sha224 = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_busy",   {255'd0, out_busy}, 256'd0);
    chk("rst_done",   {255'd0, out_done}, 256'd0);
    chk("rst_digest", out_digest, IV_DIG);
    chk("rst_state",  {254'd0, out_dbg_state}, 256'd0);
    rst = 1'b0;

    start_block(blk_abc, 1'b1, 1'b0, ABC_DIG, FULL);
    wait_done("abc");

    start_block(blk_null, 1'b1, 1'b0, NULL_DIG, FULL);
    wait_done("empty");

    start_block(blk_two1, 1'b1, 1'b0, '0, '0);
    wait_done("two_blk1");
    start_block(blk_two2, 1'b0, 1'b0, TWO_DIG, FULL);
    wait_done("two_blk2");

    // start request during ROUND must be dropped
    start_block(blk_abc, 1'b1, 1'b0, ABC_DIG, FULL);
    repeat (10) @(negedge clk);
    in_block = blk_null;
    in_init  = 1'b0;
    in_start = 1'b1;
    @(negedge clk);
    in_start = 1'b0;
    chk("busy_ignore", {255'd0, out_busy}, 256'd1);
    wait_done("ignored_start");
    repeat (4) @(negedge clk);

    // abort mid-block, then chain from the reset IV
    start_block(blk_null, 1'b1, 1'b0, NULL_DIG, FULL);
    repeat (31) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy",   {255'd0, out_busy}, 256'd0);
    chk("abort_done",   {255'd0, out_done}, 256'd0);
    chk("abort_digest", out_digest, IV_DIG);
    chk("abort_state",  {254'd0, out_dbg_state}, 256'd0);
    exp_q.delete();
    mask_q.delete();
    due_q.delete();
    last_digest = IV_DIG;
    last_known  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start_block(blk_abc, 1'b0, 1'b0, ABC_DIG, FULL);
    wait_done("abc_after_abort");

`ifdef SHA224_EN
    start_block(blk_abc, 1'b1, 1'b1,
                {224'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7, 32'h0},
                {{224{1'b1}}, 32'h0});
    wait_done("sha224_abc");
`endif

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
